hilo_div_ctrl: RTL

Multi-cycle divide sequencer for the EX stage. It runs a WIDTH-iteration restoring divide, either signed or unsigned, on operands from ID/EX. While the divide runs it freezes the pipeline by holding the stage-register enables low. The packed {remainder, quotient} result is presented to the 64-bit divide input of EX/MEM in the one cycle that the pipeline is released.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 29 ++
 rtl/hilo_div_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the EX-stage divide sequencer: FSM encoding, default
// operand width and the {hi, lo} result layout.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // HI carries the remainder, LO the quotient (MIPS hi/lo order).
  typedef struct packed {
    logic [DIV_WIDTH-1:0] hi;
    logic [DIV_WIDTH-1:0] lo;
  } hilo_t;

  function automatic hilo_t pack_hilo(input logic [DIV_WIDTH-1:0] rem,
                                      input logic [DIV_WIDTH-1:0] quo);
    hilo_t r;
    r.hi = rem;
    r.lo = quo;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration: shift {rem, quo} left, trial-subtract the
// divisor magnitude and keep the difference when no borrow occurs.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] nxt;
  logic           borrow;
  logic           unused_msb;

  always_comb begin
    sh             = {rem_i, quo_i[WIDTH-1]};
    // Borrow out of the (WIDTH+1)-bit subtract doubles as the rem < dsr compare.
    {borrow, diff} = {1'b0, sh} - {2'b00, dsr_i};
    nxt            = borrow ? sh : diff;
    rem_o          = nxt[WIDTH-1:0];
    quo_o          = {quo_i[WIDTH-2:0], ~borrow};
    unused_msb     = nxt[WIDTH];
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// EX-stage multi-cycle signed/unsigned restoring divider with pipeline stall.
// Optional macro DIV_EARLY_OUT_EN: finish at accept when |dividend| < |divisor|.
module hilo_div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               is_signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] divd_out_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               sgn_q, sgn_d;
  logic               dneg_q, dneg_d;
  logic               sneg_q, sneg_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dbz_q, dbz_d;

  logic               dvd_neg, dsr_neg;
  logic [WIDTH-1:0]   dvd_mag, dsr_mag;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    dvd_neg = is_signed_i & dividend_i[WIDTH-1];
    dsr_neg = is_signed_i & divisor_i[WIDTH-1];
    dvd_mag = dvd_neg ? -dividend_i : dividend_i;
    dsr_mag = dsr_neg ? -divisor_i  : divisor_i;
    // Quotient sign = XOR of operand signs; remainder follows the dividend.
    quo_fix = (sgn_q & (dneg_q ^ sneg_q)) ? -step_quo : step_quo;
    rem_fix = (sgn_q & dneg_q) ? -step_rem : step_rem;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    sgn_d   = sgn_q;
    dneg_d  = dneg_q;
    sneg_d  = sneg_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rem_d  = '0;
            quo_d  = dvd_mag;
            dsr_d  = dsr_mag;
            sgn_d  = is_signed_i;
            dneg_d = dvd_neg;
            sneg_d = dsr_neg;
            cnt_d  = CW'(WIDTH);
            if (dsr_mag == '0) begin
              state_d = S_DONE;
              res_d   = {dividend_i, {WIDTH{1'b1}}};
              dbz_d   = 1'b1;
`ifdef DIV_EARLY_OUT_EN
            end else if (dvd_mag < dsr_mag) begin
              state_d = S_DONE;
              res_d   = {dividend_i, {WIDTH{1'b0}}};
              dbz_d   = 1'b0;
`endif
            end else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            res_d   = {rem_fix, quo_fix};
            dbz_d   = 1'b0;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      sgn_q   <= 1'b0;
      dneg_q  <= 1'b0;
      sneg_q  <= 1'b0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      sgn_q   <= sgn_d;
      dneg_q  <= dneg_d;
      sneg_q  <= sneg_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  // Stall drops in DONE so the stage registers capture divd_out on that edge.
  assign stall_o       = ~flush_i & (((state_q == S_IDLE) & start_i) | (state_q == S_BUSY));
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE) & ~flush_i;
  assign divd_out_o    = res_q;
  assign div_by_zero_o = dbz_q;

endmodule
